axi4lite_master_bridge: RTL and testbench

- AXI4-Lite initiator. Converts a simple single-transfer local request bus (req/ack) into AXI4-Lite read and write transactions.
- Drives the register-bank responders generated in this codebase from test sequencers, CPU-less controllers and bench harnesses.
- One transaction outstanding at a time. No bursts.
- Includes a response timeout so that a dead or unmapped responder cannot hang the local side.

---
 rtl/axi4lite_master_bridge.sv | 191 +++++++++++++++++++
 tb/tb_axi4lite_master_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_bridge.sv
// AXI4-Lite initiator: turns a single-transfer req/ack local bus into AXI4-Lite
// reads and writes, one outstanding at a time, with a response timeout.
module axi4lite_master_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strb,
    output logic                  busy,
    output logic                  ack,
    output logic                  err,
    output logic [31:0]           rd_data,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp
);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  timed_out;

    // A zero limit disables the timeout entirely.
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LIMIT);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rd_data_d = rd_data_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                // Write has priority; a simultaneous read is dropped.
                if (wr_req) begin
                    awaddr_d  = addr;
                    wdata_d   = wr_data;
                    wstrb_d   = wr_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = WRITE;
                end else if (rd_req) begin
                    araddr_d  = addr;
                    arvalid_d = 1'b1;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = READ;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 16'd1;
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (bvalid && bready_q) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = bresp[1];
                    state_d   = IDLE;
                end else if (timed_out) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            READ: begin
                cnt_d = cnt_q + 16'd1;
                if (arvalid_q && arready) arvalid_d = 1'b0;
                if (rvalid && rready_q) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = rresp[1];
                    if (!rresp[1]) rd_data_d = rdata;
                    state_d   = IDLE;
                end else if (timed_out) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign ack     = ack_q;
    assign err     = err_q;
    assign rd_data = rd_data_q;
    assign awvalid = awvalid_q;
    assign awaddr  = awaddr_q;
    assign awprot  = 3'b000;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign bready  = bready_q;
    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign arprot  = 3'b000;
    assign rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Bench for axi4lite_master_bridge: directed and randomized transactions whose
// ack cycle, error flag and read data come from a cycle-count model of the responder.
module tb_axi4lite_master_bridge;

    localparam int AW = 8;
    localparam int T  = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          wr_req, rd_req;
    logic [AW-1:0] addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic          busy, ack, err;
    logic [31:0]   rd_data;
    logic          awvalid, awready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          wvalid, wready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          arvalid, arready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          rvalid, rready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;

    int            total  = 0;
    int            passed = 0;
    logic [31:0]   exp_rd = '0;

    always #5 aclk = ~aclk;

    axi4lite_master_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(T)) dut (
        .aclk(aclk), .areset(areset),
        .wr_req(wr_req), .rd_req(rd_req), .addr(addr),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .busy(busy), .ack(ack), .err(err), .rd_data(rd_data),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_req  = 1'b0; rd_req  = 1'b0;
        awready = 1'b0; wready  = 1'b0; arready = 1'b0;
        bvalid  = 1'b0; rvalid  = 1'b0;
        bresp   = 2'b00; rresp  = 2'b00;
        rdata   = $urandom;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_rready"}, rready, 0);
    endtask

    // Responder: awready from offset 1+da, wready from 1+dw, B one-cycle pulse
    // db cycles after the later of the two address/data handshakes.
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int da, input int dw, input int db, input logic [1:0] br,
                            input bit with_rd);
        int hb, ka;
        logic e;
        hb = ((da > dw) ? da : dw) + 2 + db;
        if (hb <= T + 1) begin ka = hb + 1; e = br[1]; end
        else begin ka = T + 2; e = 1'b1; end
        addr = a; wr_data = d; wr_strb = s; wr_req = 1'b1; rd_req = with_rd;
        for (int k = 1; k <= ka; k++) begin
            tick();
            wr_req = 1'b0;
            rd_req = with_rd && (k == 1);
            addr   = $urandom;
            wr_data = $urandom;
            chk("wr_busy", busy, k < ka);
            chk("wr_ack", ack, k == ka);
            chk("wr_err", err, (k == ka) ? e : 1'b0);
            chk("wr_awvalid", awvalid, (k < ka) && (k <= 1 + da));
            chk("wr_wvalid", wvalid, (k < ka) && (k <= 1 + dw));
            chk("wr_bready", bready, k < ka);
            chk("wr_arvalid", arvalid, 0);
            chk("wr_rd_data", rd_data, exp_rd);
            if (k < ka && k <= 1 + da) chk("wr_awaddr", awaddr, a);
            if (k < ka && k <= 1 + dw) begin
                chk("wr_wdata", wdata, d);
                chk("wr_wstrb", wstrb, s);
            end
            awready = (k >= 1 + da);
            wready  = (k >= 1 + dw);
            bvalid  = (k == hb);
            bresp   = br;
        end
        idle_inputs();
    endtask

    // Responder: arready from offset 1+da, R one-cycle pulse dr cycles after AR.
    task automatic do_read(input logic [AW-1:0] a, input int da, input int dr,
                           input logic [1:0] rr, input logic [31:0] rv);
        int hr, ka;
        logic e;
        logic [31:0] nr;
        hr = da + 2 + dr;
        if (hr <= T + 1) begin
            ka = hr + 1; e = rr[1];
            nr = rr[1] ? exp_rd : rv;
        end else begin
            ka = T + 2; e = 1'b1; nr = '0;
        end
        addr = a; rd_req = 1'b1;
        for (int k = 1; k <= ka; k++) begin
            tick();
            rd_req = 1'b0;
            addr   = $urandom;
            chk("rd_busy", busy, k < ka);
            chk("rd_ack", ack, k == ka);
            chk("rd_err", err, (k == ka) ? e : 1'b0);
            chk("rd_arvalid", arvalid, (k < ka) && (k <= 1 + da));
            chk("rd_rready", rready, k < ka);
            chk("rd_awvalid", awvalid, 0);
            chk("rd_bready", bready, 0);
            chk("rd_rd_data", rd_data, (k == ka) ? nr : exp_rd);
            if (k < ka && k <= 1 + da) chk("rd_araddr", araddr, a);
            arready = (k >= 1 + da);
            rvalid  = (k == hr);
            rdata   = (k == hr) ? rv : $urandom;
            rresp   = rr;
        end
        exp_rd = nr;
        idle_inputs();
    endtask

    initial begin
        areset = 1'b1;
        addr = '0; wr_data = '0; wr_strb = '0;
        idle_inputs();
        repeat (3) tick();
        chk_quiet("rst");
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("rst_awprot", awprot, 0);
        chk("rst_arprot", arprot, 0);
        areset = 1'b0;
        tick();

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        do_read(8'h10, 3, 0, 2'b00, 32'h12345678);
        do_write(8'h20, 32'hCAFEF00D, 4'h3, 2, 0, 0, 2'b10, 1'b0);
        do_write(8'h30, 32'h0BADC0DE, 4'h5, 0, 0, 1, 2'b00, 1'b1);
        tick();
        chk_quiet("drop_rd");

        do_read(8'h40, 0, 50, 2'b00, 32'hFFFFFFFF);
        tick();
        chk_quiet("to_after");
        chk("to_rd_data", rd_data, 0);
        do_read(8'h44, 1, 1, 2'b00, 32'hA5A55A5A);
        do_read(8'h48, 0, 0, 2'b10, 32'h11111111);
        do_write(8'h50, 32'h22222222, 4'hF, 0, 0, 20, 2'b00, 1'b0);

        // Reset in the middle of a stalled AW handshake.
        addr = 8'h60; wr_data = 32'h33333333; wr_strb = 4'hF; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        chk("mid_awvalid", awvalid, 1);
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        exp_rd = '0;
        chk_quiet("mid_rst");
        chk("mid_rd_data", rd_data, 0);
        do_write(8'h64, 32'h44444444, 4'h9, 1, 0, 0, 2'b00, 1'b0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(AW'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2),
                         $urandom_range(0, 2), $urandom_range(0, 2), 2'($urandom),
                         bit'($urandom_range(0, 1)));
            else
                do_read(AW'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                        2'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                tick();
                chk_quiet("gap");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
